// File: rtl/byte_frame_packer.sv
// Packs a byte stream into HEADER / payload / count / XOR-checksum frames.
// Input bytes go through a show-ahead FIFO because the input cannot be stalled.
module byte_frame_packer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LEN = 32,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              frame_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CNT  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          overflow_q, overflow_d;
  logic          drop_last_q, drop_last_d;

  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic [8:0] head;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);
  assign head  = mem_q[rd_ptr_q];
  assign pop   = (state_q == S_PAY) && !empty && out_ready;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push  = in_valid && (!full || pop);

  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    csum_d        = csum_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    drop_last_d   = drop_last_q;
    out_valid     = 1'b0;
    out_data      = '0;

    case (state_q)
      S_IDLE: begin
        if (!empty || drop_last_q) state_d = S_HDR;
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = HEADER;
        if (out_ready) state_d = S_PAY;
      end
      S_PAY: begin
        if (!empty) begin
          out_valid = 1'b1;
          out_data  = head[7:0];
          if (out_ready) begin
            count_d = count_q + 8'd1;
            csum_d  = csum_q ^ head[7:0];
            if (head[8] || (count_q + 8'd1 == MAX_LEN8)) state_d = S_CNT;
          end
        end else if (drop_last_q) begin
          // The event's last byte was lost: close the frame with what was kept.
          state_d     = S_CNT;
          drop_last_d = 1'b0;
        end
      end
      S_CNT: begin
        out_valid = 1'b1;
        out_data  = count_q;
        if (out_ready) state_d = S_CSUM;
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        if (out_ready) begin
          frame_count_d = frame_count_q + 16'd1;
          count_d       = '0;
          csum_d        = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_valid && !push) begin
      overflow_d = 1'b1;
      if (in_last) drop_last_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_byte};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      state_q       <= S_IDLE;
      count_q       <= '0;
      csum_q        <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      drop_last_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      state_q       <= state_d;
      count_q       <= count_d;
      csum_q        <= csum_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      drop_last_q   <= drop_last_d;
    end
  end

endmodule

// File: tb/tb_byte_frame_packer.sv
// Self-checking bench for byte_frame_packer: table of simple frames plus
// hand-written corner sequences, with a beat scoreboard on the output.
module tb_byte_frame_packer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned MAX_LEN = 32;

  logic       clk;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fifo_level;
  logic       overflow;
  logic [15:0] frame_count;

  byte_frame_packer #(
    .DEPTH  (DEPTH),
    .MAX_LEN(MAX_LEN),
    .HEADER (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         fails  = 0;
  int         beats  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data    = '0;

  typedef struct {
    int         n;
    logic [7:0] first;
    logic [7:0] step;
    logic [7:0] cnt;
    logic [7:0] csum;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame builder: header, payload, byte count, XOR of payload.
  task automatic model_frame();
    logic [7:0] x;
    x = '0;
    exp_q.push_back(8'hA5);
    foreach (pay[k]) begin
      exp_q.push_back(pay[k]);
      x ^= pay[k];
    end
    exp_q.push_back(8'(pay.size()));
    exp_q.push_back(x);
    pay.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_level != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          check("beat", out_data, exp_q.pop_front());
        end
        beats++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    reset     = 1'b0;
    in_byte   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    tbl[0] = '{3, 8'h11, 8'h11, 8'h03, 8'h00, 16'd1};
    tbl[1] = '{1, 8'h55, 8'h00, 8'h01, 8'h55, 16'd2};
    tbl[2] = '{4, 8'hF0, 8'h01, 8'h04, 8'h00, 16'd3};
    tbl[3] = '{2, 8'h80, 8'h01, 8'h02, 8'h01, 16'd4};
    tbl[4] = '{5, 8'h01, 8'h01, 8'h05, 8'h01, 16'd5};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hA5);
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].first + 8'(j) * tbl[i].step);
      exp_q.push_back(tbl[i].cnt);
      exp_q.push_back(tbl[i].csum);
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].first + 8'(j) * tbl[i].step, j == tbl[i].n - 1);
      drain("table_frame");
      check("table_frame_count", frame_count, tbl[i].fc);
      check("table_overflow", overflow, 0);
    end

    // Header latency: write cycle, then IDLE->HDR.
    pay.push_back(8'h77);
    model_frame();
    send(8'h77, 1'b1);
    check("lat_idle_valid", out_valid, 0);
    check("lat_level", fifo_level, 1);
    @(posedge clk);
    #1;
    check("lat_hdr_valid", out_valid, 1);
    check("lat_hdr_data", out_data, 8'hA5);
    drain("latency");
    check("lat_frame_count", frame_count, 6);

    // Backpressure while the second payload byte is presented.
    pay = '{8'h11, 8'h22, 8'h33};
    model_frame();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    n = 0;
    while (!(out_valid && out_data == 8'h22) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_found_22", n < 50, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_data", out_data, 8'h22);
    end
    out_ready = 1'b1;
    drain("backpressure");
    check("bp_frame_count", frame_count, 7);

    // Simultaneous push and pop while full.
    out_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      pay.push_back(8'h40 + 8'(j));
      send(8'h40 + 8'(j), 1'b0);
    end
    pay.push_back(8'h50);
    model_frame();
    check("full_level", fifo_level, 16);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("full_pay_level", fifo_level, 16);
    send(8'h50, 1'b1);
    check("pushpop_level", fifo_level, 16);
    check("pushpop_overflow", overflow, 0);
    drain("pushpop");
    check("pushpop_frame_count", frame_count, 8);

    // MAX_LEN split: 34 bytes, last on the 34th.
    for (int j = 1; j <= 32; j++) pay.push_back(8'(j));
    model_frame();
    pay = '{8'h21, 8'h22};
    model_frame();
    for (int j = 1; j <= 34; j++) send(8'(j), j == 34);
    drain("maxlen");
    check("maxlen_frame_count", frame_count, 10);
    check("maxlen_overflow", overflow, 0);

    // Overflow: 20 bytes into 16 entries, last byte dropped.
    out_ready = 1'b0;
    for (int j = 1; j <= 20; j++) send(8'(j), j == 20);
    check("ovf_level", fifo_level, 16);
    check("ovf_flag", overflow, 1);
    for (int j = 1; j <= 16; j++) pay.push_back(8'(j));
    model_frame();
    out_ready = 1'b1;
    drain("overflow");
    check("ovf_frame_count", frame_count, 11);
    check("ovf_sticky", overflow, 1);

    // Zero-payload frame from a dropped last byte with an empty FIFO.
    out_ready = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      pay.push_back(8'h60 + 8'(j));
      send(8'h60 + 8'(j), j == 16);
    end
    send(8'h99, 1'b1);
    model_frame();
    model_frame();
    check("zero_level", fifo_level, 16);
    out_ready = 1'b1;
    drain("zero_payload");
    check("zero_frame_count", frame_count, 13);

    // Reset after two payload beats.
    pay = '{8'h11, 8'h22, 8'h33};
    model_frame();
    b0 = beats;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    n = 0;
    while (beats - b0 < 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrst_reached", n < 50, 1);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_overflow", overflow, 0);
    exp_q.delete();
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    pay.push_back(8'h55);
    model_frame();
    send(8'h55, 1'b1);
    drain("post_reset");
    check("post_reset_frame_count", frame_count, 1);
    check("post_reset_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/byte_frame_packer.md
Name: byte_frame_packer

Overview:
- Stage directly downstream of DataProcessing: consumes its 8-bit output stream (outData8) one byte per qualified cycle and packs it into framed byte packets for the readout link.
- Frame format: HEADER byte, payload bytes, count byte, XOR checksum byte.
- Input bytes are buffered in an internal show-ahead FIFO, because the input has no backpressure and the output is ready/valid.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 4..256); each entry is 9 bits: byte plus last flag.
- MAX_LEN, 32, maximum payload bytes per frame (1..255).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_byte  input  8  byte from DataProcessing (outData8).
- in_valid  input  1  in_byte is valid this cycle.
- in_last  input  1  in_byte is the final byte of an event.
- out_data  output  8  framed byte stream.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one input byte was dropped.
- frame_count  output  16  completed frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; FIFO empty; fifo_level=0; out_valid=0; out_data=0; overflow=0; frame_count=0; internal payload count=0, checksum=0, drop_last=0.
- Write path:
  - A byte is written when in_valid=1 and (fifo_level<DEPTH, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped and overflow is set.
  - A dropped byte with in_last=1 sets drop_last.
  - fifo_level is updated the cycle after a push/pop; a simultaneous push and pop leaves it unchanged.
- Transfer rule:
  - A beat transfers when out_valid && out_ready.
  - Once out_valid=1, out_data and out_valid must hold stable until the transfer.
- FSM:
  - IDLE: out_valid=0. Go to HDR when the FIFO is non-empty or drop_last=1.
  - HDR: out_valid=1, out_data=HEADER. On transfer go to PAY.
  - PAY:
    - out_valid=fifo non-empty, out_data=FIFO head.
    - On transfer: pop; count+=1; csum^=byte.
    - Go to CNT if the head's last flag is 1 or count+1==MAX_LEN; otherwise stay.
    - If the FIFO is empty and drop_last=1: go to CNT with no beat, and clear drop_last.
  - CNT: out_valid=1, out_data=count. On transfer go to CSUM.
  - CSUM: out_valid=1, out_data=csum (XOR of payload bytes only). On transfer: frame_count+=1; clear count and csum; go to IDLE.
- MAX_LEN close:
  - The next FIFO byte starts a new frame; no event-boundary marker is inserted.
  - A last flag on exactly the MAX_LEN-th byte closes only that one frame.
- Zero-payload frame (drop_last with no buffered byte) emits: A5, 00, 00.
- Latency: with out_ready=1 and an empty FIFO, the header beat has out_valid=1 two cycles after the first byte's in_valid edge (write cycle, then IDLE→HDR), and one beat per cycle follows.
- overflow clears only on reset.

Test Plan:
- Basic frame:
  - Stimulus: bytes 11,22,33 with in_last on 33; out_ready=1.
  - Response: out beats A5,11,22,33,03,00; frame_count=1; overflow=0.
- MAX_LEN split:
  - Stimulus: 34 bytes 01..22, last on 22; DEPTH=64; out_ready=1.
  - Response: frame 1 is A5,01..20,20,20; frame 2 is A5,21,22,02,03; frame_count=2.
- Backpressure:
  - Stimulus: same stimulus as Basic frame; drop out_ready for 5 cycles while out_data=22.
  - Response: out_data holds 22 with out_valid=1 throughout; the full beat sequence is unchanged and nothing is duplicated.
- Overflow:
  - Stimulus: DEPTH=16, out_ready=0; push 20 bytes 01..14 with last on 14.
  - Response:
    - fifo_level=16 and overflow=1; bytes 11..14 are dropped and drop_last=1.
    - After releasing out_ready: A5, then 01..10 in PAY, then drop_last closes the frame, giving A5,01..10,10,10.
- Simultaneous push/pop at full:
  - Stimulus: fifo_level=16 and PAY popping with out_ready=1; push one byte in the same cycle.
  - Response: the byte is accepted; fifo_level stays 16; overflow stays 0.
- Reset mid-frame:
  - Stimulus: assert reset during PAY after 2 payload beats.
  - Response: out_valid=0 immediately (asynchronous); fifo_level=0; frame_count=0. A new event 55 (last) then yields A5,55,01,55.
